camera_capture_ctrl: RTL and testbench

// Sequences OV7670 frame capture once SCCB configuration is done. Arms on request,

---
 rtl/camera_capture_ctrl_if.sv | 28 ++
 rtl/camera_capture_ctrl.sv | 127 ++++++++++++
 tb/tb_camera_capture_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/camera_capture_ctrl_if.sv
// Pixel-input / frame-buffer-write bundle for camera_capture_ctrl.
// master = capture controller, slave = camera pins plus frame-buffer RAM side.
interface camera_capture_ctrl_if #(
  parameter int ADDR_W = 19
);
  logic              cfg_done;
  logic              capture_req;
  logic              continuous;
  logic              vsync;
  logic              href;
  logic [7:0]        p_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic              busy;
  logic              frame_done;
  logic              frame_err;

  modport master (
    input  cfg_done, capture_req, continuous, vsync, href, p_data,
    output wr_en, wr_addr, wr_data, busy, frame_done, frame_err
  );

  modport slave (
    output cfg_done, capture_req, continuous, vsync, href, p_data,
    input  wr_en, wr_addr, wr_data, busy, frame_done, frame_err
  );
endinterface

// File: rtl/camera_capture_ctrl.sv
// OV7670 frame capture sequencer: packs href byte pairs into RGB565 frame-buffer writes.
// Optional 2x2 decimation when CAPTURE_DECIMATE_EN is defined.
module camera_capture_ctrl #(
  parameter int H_PIXELS = 640,
  parameter int V_LINES  = 480,
  parameter int ADDR_W   = 19
) (
  input  logic                  clk,
  input  logic                  rst,
  camera_capture_ctrl_if.master bus
);

`ifdef CAPTURE_DECIMATE_EN
  localparam bit DECIMATE = 1'b1;
`else
  localparam bit DECIMATE = 1'b0;
`endif
  localparam int unsigned   BOUND   = DECIMATE ? (H_PIXELS / 2) * (V_LINES / 2)
                                               : H_PIXELS * V_LINES;
  localparam logic [ADDR_W:0] BOUND_C = (ADDR_W + 1)'(BOUND);
  localparam logic [15:0]     H_C     = 16'(H_PIXELS);
  localparam logic [15:0]     V_C     = 16'(V_LINES);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_CAPTURE, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              vsync_q, href_q, phase_q;
  logic [7:0]        hi_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [ADDR_W:0]   addr_cnt_q;   // one bit wider so the bound itself is representable
  logic [15:0]       wr_data_q;
  logic [15:0]       line_cnt_q, pix_cnt_q;
  logic              frame_err_q;

  logic start_cap, in_cap, pix_done, line_end, keep_pix, at_bound;
  logic do_write, overflow, line_err, frame_len_err, vsync_rise;
  logic [15:0] line_cnt_inc;

  always_comb begin
    state_d   = state_q;
    start_cap = 1'b0;
    unique case (state_q)
      S_IDLE:    if (bus.capture_req && bus.cfg_done) state_d = S_ARM;
      S_ARM: begin
        if (!bus.cfg_done) begin
          state_d = S_IDLE;
        end else if (vsync_q && !bus.vsync) begin
          state_d   = S_CAPTURE;
          start_cap = 1'b1;
        end
      end
      S_CAPTURE: if (vsync_rise) state_d = S_DONE;
      S_DONE:    state_d = bus.continuous ? S_ARM : S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    vsync_rise    = !vsync_q && bus.vsync;
    in_cap        = (state_q == S_CAPTURE);
    pix_done      = in_cap && bus.href && phase_q;
    line_end      = in_cap && href_q && !bus.href;
    // Decimation keeps even pixels of even lines, indexed before this pixel/line is counted.
    keep_pix      = !DECIMATE || (!pix_cnt_q[0] && !line_cnt_q[0]);
    at_bound      = (addr_cnt_q == BOUND_C);
    do_write      = pix_done && keep_pix && !at_bound;
    overflow      = pix_done && keep_pix && at_bound;
    line_err      = line_end && (phase_q || (pix_cnt_q != H_C));
    line_cnt_inc  = line_cnt_q + {15'd0, line_end};
    frame_len_err = in_cap && vsync_rise && (line_cnt_inc != V_C);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      vsync_q     <= 1'b1;
      href_q      <= 1'b0;
      phase_q     <= 1'b0;
      hi_q        <= 8'd0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      addr_cnt_q  <= '0;
      wr_data_q   <= 16'd0;
      line_cnt_q  <= 16'd0;
      pix_cnt_q   <= 16'd0;
      frame_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vsync_q <= bus.vsync;
      href_q  <= bus.href;
      wr_en_q <= do_write;
      if (do_write) begin
        wr_data_q  <= {hi_q, bus.p_data};
        wr_addr_q  <= addr_cnt_q[ADDR_W-1:0];
        addr_cnt_q <= addr_cnt_q + 1'b1;
      end
      if (start_cap) begin
        wr_addr_q   <= '0;
        addr_cnt_q  <= '0;
        line_cnt_q  <= 16'd0;
        pix_cnt_q   <= 16'd0;
        phase_q     <= 1'b0;
        frame_err_q <= 1'b0;
      end else if (in_cap) begin
        if (bus.href && !phase_q) hi_q <= bus.p_data;
        phase_q <= bus.href ? ~phase_q : 1'b0;
        if (pix_done) pix_cnt_q <= pix_cnt_q + 16'd1;
        if (line_end) begin
          line_cnt_q <= line_cnt_inc;
          pix_cnt_q  <= 16'd0;
        end
        if (line_err || overflow || frame_len_err) frame_err_q <= 1'b1;
      end else begin
        phase_q <= 1'b0;
      end
    end
  end

  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.frame_done = (state_q == S_DONE);
  assign bus.frame_err  = frame_err_q;

endmodule

// File: tb/tb_camera_capture_ctrl.sv
// Randomized bench for camera_capture_ctrl on a 4x3 frame with a frame-level reference model.
// Define CAPTURE_DECIMATE_EN for both bench and RTL to exercise 2x2 decimation.
module tb_camera_capture_ctrl;

  localparam int H      = 4;
  localparam int V      = 3;
  localparam int ADDR_W = 4;
`ifdef CAPTURE_DECIMATE_EN
  localparam bit DECIMATE = 1'b1;
`else
  localparam bit DECIMATE = 1'b0;
`endif
  localparam int BOUND = DECIMATE ? (H / 2) * (V / 2) : H * V;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  camera_capture_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  camera_capture_ctrl #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  int          done_cnt;
  logic        last_err;
  int          n_lines;
  int          line_len[8];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (bus.wr_en) got_q.push_back({16'(bus.wr_addr), bus.wr_data});
    if (bus.frame_done) begin
      done_cnt++;
      last_err = bus.frame_err;
    end
  end

  function automatic bit keep(input int pix, input int line);
    return !DECIMATE || ((pix % 2 == 0) && (line % 2 == 0));
  endfunction

  task automatic pulse_req();
    bus.capture_req = 1'b1;
    tick();
    bus.capture_req = 1'b0;
  endtask

  // Drives one frame; the model derives the write list and error flag from the frame shape.
  task automatic run_frame(input bit expect_cap, input bit seq_data, input string name);
    int         nwr;
    int         seqv;
    bit         err;
    logic [7:0] b;
    logic [7:0] hi;
    got_q.delete();
    exp_q.delete();
    done_cnt = 0;
    nwr  = 0;
    seqv = 0;
    hi   = 8'd0;
    err  = (n_lines != V);
    bus.vsync = 1'b1;
    bus.href  = 1'b0;
    repeat (3) tick();
    bus.vsync = 1'b0;
    repeat (2) tick();
    for (int l = 0; l < n_lines; l++) begin
      if (line_len[l] != 2 * H) err = 1'b1;
      bus.href = 1'b1;
      for (int k = 0; k < line_len[l]; k++) begin
        b = seq_data ? 8'(seqv) : 8'($urandom);
        seqv++;
        bus.p_data = b;
        if (k % 2 == 0) begin
          hi = b;
        end else if (keep(k / 2, l)) begin
          if (nwr < BOUND) begin
            exp_q.push_back({16'(nwr), hi, b});
            nwr++;
          end else begin
            err = 1'b1;
          end
        end
        tick();
      end
      bus.href   = 1'b0;
      bus.p_data = 8'd0;
      repeat ($urandom_range(2, 4)) tick();
    end
    bus.vsync = 1'b1;
    tick();
    for (int i = 0; i < 10 && done_cnt == 0; i++) tick();
    if (!expect_cap) begin
      exp_q.delete();
      err = 1'b0;
    end
    check_eq({name, ".n_writes"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check_eq($sformatf("%s.write%0d", name, i), got_q[i], exp_q[i]);
    check_eq({name, ".frame_done"}, done_cnt, expect_cap ? 1 : 0);
    if (expect_cap) check_eq({name, ".frame_err"}, last_err, err);
  endtask

  task automatic clean_shape();
    n_lines = V;
    for (int l = 0; l < 8; l++) line_len[l] = 2 * H;
  endtask

  initial begin
    rst             = 1'b1;
    bus.cfg_done    = 1'b0;
    bus.capture_req = 1'b0;
    bus.continuous  = 1'b0;
    bus.vsync       = 1'b1;
    bus.href        = 1'b0;
    bus.p_data      = 8'd0;
    done_cnt        = 0;
    last_err        = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check_eq("rst.busy", bus.busy, 0);
    check_eq("rst.wr_en", bus.wr_en, 0);
    check_eq("rst.wr_addr", bus.wr_addr, 0);
    check_eq("rst.wr_data", bus.wr_data, 0);
    check_eq("rst.frame_done", bus.frame_done, 0);
    check_eq("rst.frame_err", bus.frame_err, 0);
    tick();
    rst = 1'b0;
    tick();

    // Clean frame with sequential bytes
    bus.cfg_done = 1'b1;
    clean_shape();
    pulse_req();
    run_frame(1'b1, 1'b1, "clean");
    check_eq("clean.idle_after", bus.busy, 0);

    // Request without configuration is dropped
    bus.cfg_done = 1'b0;
    pulse_req();
    @(negedge clk);
    check_eq("nocfg.busy", bus.busy, 0);
    run_frame(1'b0, 1'b0, "nocfg");
    bus.cfg_done = 1'b1;

    // Continuous: two back-to-back frames, then return to IDLE
    bus.continuous = 1'b1;
    pulse_req();
    run_frame(1'b1, 1'b0, "cont1");
    check_eq("cont1.rearmed", bus.busy, 1);
    bus.continuous = 1'b0;
    run_frame(1'b1, 1'b0, "cont2");
    check_eq("cont2.idle_after", bus.busy, 0);

    // Odd-length line, then a clean frame clears the error
    clean_shape();
    line_len[1] = 7;
    pulse_req();
    run_frame(1'b1, 1'b0, "oddline");
    clean_shape();
    pulse_req();
    run_frame(1'b1, 1'b0, "recover");

    // Too many lines hits the address bound
    clean_shape();
    n_lines = 4;
    pulse_req();
    run_frame(1'b1, 1'b0, "extraline");

    // Reset mid-line
    clean_shape();
    pulse_req();
    bus.vsync = 1'b1;
    repeat (3) tick();
    bus.vsync = 1'b0;
    repeat (2) tick();
    bus.href = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus.p_data = 8'($urandom);
      tick();
    end
    rst = 1'b1;
    tick();
    @(negedge clk);
    check_eq("midrst.busy", bus.busy, 0);
    check_eq("midrst.wr_en", bus.wr_en, 0);
    rst      = 1'b0;
    bus.href = 1'b0;
    bus.vsync = 1'b1;
    repeat (2) tick();
    pulse_req();
    run_frame(1'b1, 1'b0, "afterrst");

    // Randomized frame shapes
    for (int r = 0; r < 6; r++) begin
      n_lines = $urandom_range(2, 4);
      for (int l = 0; l < 8; l++)
        line_len[l] = ($urandom_range(0, 2) == 0) ? $urandom_range(5, 10) : 2 * H;
      pulse_req();
      run_frame(1'b1, 1'b0, $sformatf("rand%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
